// File: rtl/chacha_qr_sched.sv
// ChaCha20 block controller: holds the input and working states and time-shares one
// external combinational quarter-round unit over 10 double rounds (80 issues).
module chacha_qr_sched #(
   parameter int num_bits = 32
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [num_bits-1:0] MatQ,
   input  logic [3:0]          Double_Word,
   input  logic                Carregar,
   input  logic                Iniciar,
   input  logic                Descarrega,
   output logic [num_bits-1:0] Resultado,
   output logic                Pronto,
   output logic                Ocupado,
   output logic [num_bits-1:0] qr_a,
   output logic [num_bits-1:0] qr_b,
   output logic [num_bits-1:0] qr_c,
   output logic [num_bits-1:0] qr_d,
   input  logic [num_bits-1:0] qr_a_s,
   input  logic [num_bits-1:0] qr_b_s,
   input  logic [num_bits-1:0] qr_c_s,
   input  logic [num_bits-1:0] qr_d_s
);

   typedef enum logic [2:0] {
      IDLE,
      COPY,
      ROUND,
      ADD,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [num_bits-1:0] key   [8];
   logic [num_bits-1:0] ctr;
   logic [num_bits-1:0] nonce [3];
   logic [num_bits-1:0] work  [16];
   logic [num_bits-1:0] init_w[16];

   logic [2:0] qr_idx;
   logic [3:0] dr_cnt;
   logic [3:0] rd_ptr;
   logic [3:0] ia, ib, ic, id;
   logic       last_issue;
   logic       last_unload;

   assign last_issue  = (qr_idx == 3'd7) && (dr_cnt == 4'd9);
   assign last_unload = Descarrega && (rd_ptr == 4'd15);

   assign Pronto  = (state == DONE);
   assign Ocupado = (state == COPY) || (state == ROUND) || (state == ADD);

   // The 16-word input state is a fixed view over the loadable registers
   always_comb begin
      init_w[0] = num_bits'(32'h61707865);
      init_w[1] = num_bits'(32'h3320646e);
      init_w[2] = num_bits'(32'h79622d32);
      init_w[3] = num_bits'(32'h6b206574);
      for (int i = 0; i < 8; i++) begin
         init_w[4 + i] = key[i];
      end
      init_w[12] = ctr;
      for (int i = 0; i < 3; i++) begin
         init_w[13 + i] = nonce[i];
      end
   end

   // Issues 0-3 are the column rounds, 4-7 the diagonal rounds
   always_comb begin
      {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8, 4'd12};
      case (qr_idx)
         3'd0: {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8,  4'd12};
         3'd1: {ia, ib, ic, id} = {4'd1, 4'd5, 4'd9,  4'd13};
         3'd2: {ia, ib, ic, id} = {4'd2, 4'd6, 4'd10, 4'd14};
         3'd3: {ia, ib, ic, id} = {4'd3, 4'd7, 4'd11, 4'd15};
         3'd4: {ia, ib, ic, id} = {4'd0, 4'd5, 4'd10, 4'd15};
         3'd5: {ia, ib, ic, id} = {4'd1, 4'd6, 4'd11, 4'd12};
         3'd6: {ia, ib, ic, id} = {4'd2, 4'd7, 4'd8,  4'd13};
         3'd7: {ia, ib, ic, id} = {4'd3, 4'd4, 4'd9,  4'd14};
         default: {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8, 4'd12};
      endcase
   end

   assign qr_a = (state == ROUND) ? work[ia] : '0;
   assign qr_b = (state == ROUND) ? work[ib] : '0;
   assign qr_c = (state == ROUND) ? work[ic] : '0;
   assign qr_d = (state == ROUND) ? work[id] : '0;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Iniciar) state_nxt = COPY;
         COPY:    state_nxt = ROUND;
         ROUND:   if (last_issue) state_nxt = ADD;
         ADD:     state_nxt = DONE;
         DONE:    if (last_unload) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A load in the same cycle as a start lands before COPY reads the input state
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) key[i] <= '0;
         for (int i = 0; i < 3; i++) nonce[i] <= '0;
         for (int i = 0; i < 16; i++) work[i] <= '0;
         ctr       <= '0;
         qr_idx    <= '0;
         dr_cnt    <= '0;
         rd_ptr    <= '0;
         Resultado <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Carregar) begin
                  if (Double_Word[3] == 1'b0) begin
                     key[Double_Word[2:0]] <= MatQ;
                  end else if (Double_Word == 4'd8) begin
                     ctr <= MatQ;
                  end else if (Double_Word <= 4'd11) begin
                     nonce[Double_Word[1:0] - 2'd1] <= MatQ;
                  end
               end
            end
            COPY: begin
               for (int i = 0; i < 16; i++) work[i] <= init_w[i];
               qr_idx <= '0;
               dr_cnt <= '0;
               rd_ptr <= '0;
            end
            ROUND: begin
               work[ia] <= qr_a_s;
               work[ib] <= qr_b_s;
               work[ic] <= qr_c_s;
               work[id] <= qr_d_s;
               qr_idx   <= qr_idx + 3'd1;
               if (qr_idx == 3'd7) begin
                  dr_cnt <= (dr_cnt == 4'd9) ? 4'd0 : dr_cnt + 4'd1;
               end
            end
            ADD: begin
               for (int i = 0; i < 16; i++) work[i] <= work[i] + init_w[i];
            end
            DONE: begin
               if (Descarrega) begin
                  Resultado <= work[rd_ptr];
                  rd_ptr    <= rd_ptr + 4'd1;
                  if (rd_ptr == 4'd15) begin
                     ctr <= ctr + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/chacha_qr_sched.md
# chacha_qr_sched

Controller that sequences one shared, external combinational quarter-round unit over the full 16-word ChaCha20 state. It loads key, block counter and nonce words, runs 10 double rounds (80 quarter-round issues), adds the initial state back in, and serialises the 16 result words. It sits between the host load/unload strobes and the quarter-round datapath, and owns all state storage.

## Interface
- num_bits, 32, word width; every state word and every quarter-round operand has this width.
- Clk  in  1  system clock; every register updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- MatQ  in  num_bits  load data word.
- Double_Word  in  4  load index: 0–7 key, 8 counter, 9–11 nonce; 12–15 ignored.
- Carregar  in  1  load strobe, sampled on Clk.
- Iniciar  in  1  start request, sampled on Clk.
- Descarrega  in  1  unload strobe, sampled on Clk.
- Resultado  out  num_bits  registered output word.
- Pronto  out  1  result available.
- Ocupado  out  1  block computing.
- qr_a, qr_b, qr_c, qr_d  out  num_bits each  operands to the quarter-round unit.
- qr_a_s, qr_b_s, qr_c_s, qr_d_s  in  num_bits each  same-cycle results from the quarter-round unit.

## Operation
- **Input state.** The input state is 16 words:
  - words 0–3: constants 61707865, 3320646e, 79622d32, 6b206574 (fixed);
  - words 4–11: key[0..7];
  - word 12: counter;
  - words 13–15: nonce[0..2].
- A separate 16-word working state holds the block being computed.
- **States:**
  - IDLE → COPY on Iniciar.
  - COPY → ROUND after 1 cycle.
  - ROUND → ADD after 80 cycles.
  - ADD → DONE after 1 cycle.
  - DONE → IDLE after 16 unloads.
- **IDLE:**
  - Carregar writes MatQ into the input word selected by Double_Word.
  - Iniciar moves to COPY.
  - Carregar and Iniciar in the same cycle: the load is applied first, and the start includes the new word.
- **COPY:** working state ← input state.
- **ROUND:** qr_idx (3 bits) and dr_cnt (4 bits, 0–9). Each cycle the controller drives the working words selected by qr_idx onto qr_a..qr_d and writes qr_*_s back to the same indices.
  - Column issues (qr_idx 0–3): (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - Diagonal issues (qr_idx 4–7): (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - qr_idx wraps 7→0 and increments dr_cnt.
  - Leave ROUND when qr_idx=7 and dr_cnt=9.
- **ADD:** working[i] ← working[i] + input[i] mod 2^num_bits for all 16 words in one cycle; carries are discarded.
- **DONE:**
  - Pronto=1.
  - Each Descarrega cycle: Resultado ← working[rd_ptr], then rd_ptr increments, in order 0..15.
  - On the 16th unload: return to IDLE, Pronto=0, and input counter ← counter+1 (wraps FFFFFFFF→00000000).
- **Ignored inputs:**
  - Carregar outside IDLE.
  - Iniciar outside IDLE.
  - Descarrega outside DONE.
- qr_a..qr_d are 0 outside ROUND.
- **Reset:** from any state, including mid-ROUND or mid-unload:
  - state=IDLE;
  - key, counter, nonce, working words, qr_idx, dr_cnt and rd_ptr all cleared to 0;
  - Resultado=0, Pronto=0, Ocupado=0.

## Timing
- Edge E0 samples Iniciar in IDLE; Ocupado=1 from E0.
- E1: COPY completes.
- E2–E81: 80 quarter-round issues.
- E82: ADD completes; Pronto=1 and Ocupado=0 from E82. Latency is 82 cycles.
- Resultado updates on the same edge that samples Descarrega. Data is valid the following cycle and is held until the next unload or reset.
- Back-to-back Descarrega is allowed (one word per cycle).
- A new Iniciar is accepted in the first IDLE cycle after the 16th unload.

## Test plan
- **Reset values:** assert Reset for 2 cycles → Resultado=0, Pronto=0, Ocupado=0, qr_a..qr_d=0.
- **RFC 8439 §2.3.2 block** (behavioural quarter-round model attached):
  - Load key 03020100, 07060504, …, 1f1e1d1c; counter 00000001; nonce 09000000, 4a000000, 00000000; pulse Iniciar.
  - Expected: Pronto exactly 82 cycles after the Iniciar sampling edge.
  - 16 unloads give e4e7f110, 15593bd1, 1fdd0f50, c47120a3, c7f4d1c7, 0368c033, 9aaa2204, 4e6cd4c3, 466482d2, 09aa9f07, 05d7c214, a2028bd9, d19c12b5, b94e16de, e883d0cb, 4e3c50a2.
- **Issue order:** monitor qr_a..qr_d during ROUND. Word-index sequence matches the column/diagonal tables for all 80 cycles, and Carregar/Iniciar pulses in ROUND change nothing.
- **Counter wrap:** counter=FFFFFFFF; complete one block and its 16 unloads. A second block then computes with word 12 = 00000000, and its unload of word 12 equals 00000000 + final working word 12.
- **Reset mid-operation:** Reset at E40 (mid-ROUND) and again after 5 unloads → IDLE with all outputs 0. A fresh load and start then reproduces the RFC vector exactly.
- **Load/start collision:** in IDLE, Carregar (Double_Word=8, MatQ=00000001) in the same cycle as Iniciar → the result matches the RFC vector. Double_Word=12 writes change nothing.
